mem_arbiter: RTL and testbench

- Shares the single Memory master port between N requesters, for example instruction fetch and load/store. One transaction is outstanding at a time.
- Arbitration is round-robin.
- Sits between the core's requester units and the Memory interface. It drives the m_* request channel and s_ready, and consumes m_ready, s_valid and s_data.
- Every accepted request, read or write, produces exactly one response beat, which is routed back to the requester that issued it.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester, memory-request and memory-response signals shared between the
// arbiter (slave view) and the surrounding requesters plus memory (master view).
interface mem_arbiter_if #(
  parameter int N          = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_ready;
  logic [N*ADDR_WIDTH-1:0] req_address;
  logic [N*DATA_WIDTH-1:0] req_data;
  logic [N-1:0]            req_write;
  logic [N-1:0]            rsp_valid;
  logic [N-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [ADDR_WIDTH-1:0]   m_address;
  logic [DATA_WIDTH-1:0]   m_data;
  logic                    m_valid;
  logic                    m_write;
  logic                    m_ready;
  logic [DATA_WIDTH-1:0]   s_data;
  logic                    s_valid;
  logic                    s_ready;

  modport slave (
    input  req_valid, req_address, req_data, req_write, rsp_ready,
           m_ready, s_data, s_valid,
    output req_ready, rsp_valid, rsp_data, m_address, m_data, m_valid,
           m_write, s_ready
  );

  modport master (
    output req_valid, req_address, req_data, req_write, rsp_ready,
           m_ready, s_data, s_valid,
    input  req_ready, rsp_valid, rsp_data, m_address, m_data, m_valid,
           m_write, s_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among N requesters, one transaction
// in flight.  state | meaning: IDLE | arbitrate; REQ | m_* presented; RSP | await beat
module mem_arbiter #(
  parameter int N          = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_arbiter_if.slave         bus,
  output logic [$clog2(N)-1:0] grant,
  output logic                 busy
);
  localparam int GW = $clog2(N);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [GW-1:0]         r_last;
  logic [GW-1:0]         r_owner;
  logic                  r_m_valid;
  logic [ADDR_WIDTH-1:0] r_m_address;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_write;
  logic                  w_found;
  logic [GW-1:0]         w_win;
  logic [GW-1:0]         w_cand;

  // Scan from the slot after the previous owner so it gets lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = GW'((int'(r_last) + k) % N);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.s_ready   = 1'b0;
    bus.rsp_data  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          bus.req_ready[w_win] = 1'b1;
          w_state_next         = REQ;
        end
      end
      REQ: begin
        if (r_m_valid && bus.m_ready) w_state_next = RSP;
      end
      RSP: begin
        bus.s_ready            = bus.rsp_ready[r_owner];
        bus.rsp_valid[r_owner] = bus.s_valid;
        bus.rsp_data           = bus.s_data;
        if (bus.s_valid && bus.rsp_ready[r_owner]) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_m_valid   <= 1'b0;
      r_m_address <= '0;
      r_m_data    <= '0;
      r_m_write   <= 1'b0;
      r_owner     <= '0;
      r_last      <= GW'(N - 1);
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_m_address <= bus.req_address[int'(w_win) * ADDR_WIDTH +: ADDR_WIDTH];
            r_m_data    <= bus.req_data[int'(w_win) * DATA_WIDTH +: DATA_WIDTH];
            r_m_write   <= bus.req_write[w_win];
            r_m_valid   <= 1'b1;
            r_owner     <= w_win;
          end
        end
        REQ: begin
          if (r_m_valid && bus.m_ready) r_m_valid <= 1'b0;
        end
        RSP: begin
          if (bus.s_valid && bus.rsp_ready[r_owner]) r_last <= r_owner;
        end
        default: r_m_valid <= 1'b0;
      endcase
    end
  end

  assign bus.m_valid   = r_m_valid;
  assign bus.m_address = r_m_address;
  assign bus.m_data    = r_m_data;
  assign bus.m_write   = r_m_write;
  assign grant         = r_owner;
  assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver predicts each grant and response
// with a round-robin model; a negedge monitor pops and compares what the DUT shows.
module tb_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = $clog2(N);

  typedef struct { int w; logic [AW-1:0] a; logic [DW-1:0] d; logic wr; } req_t;
  typedef struct { int w; logic [DW-1:0] d; } rsp_t;

  logic          clk;
  logic          rst_n;
  logic [GW-1:0] grant;
  logic          busy;

  int   checks = 0;
  int   errors = 0;
  int   m_last = N - 1;
  logic spur   = 1'b0;

  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];
  logic          wr_a   [N];

  int   exp_grant_q[$];
  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_d;
  logic          prev_wr;
  int            mw;
  req_t          mr;
  rsp_t          ms;

  mem_arbiter_if #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Reference arbitration: first valid requester after the previous owner.
  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return 0;
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < N; i++) begin
      bus.req_address[i*AW +: AW] = addr_a[i];
      bus.req_data[i*DW +: DW]    = data_a[i];
      bus.req_write[i]            = wr_a[i];
    end
  endtask

  task automatic rand_payload(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !bus.req_valid[i]) begin
        addr_a[i] = $urandom();
        data_a[i] = $urandom();
        wr_a[i]   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic spur_drive();
    bus.s_valid = ($urandom_range(0, 1) == 1);
    bus.s_data  = $urandom();
    spur        = bus.s_valid;
  endtask

  task automatic do_txn(input logic [N-1:0] mask, input int mstall, input int sdelay,
                        input int rstall, input logic [DW-1:0] sd);
    logic [N-1:0] vmask;
    logic [N-1:0] rr;
    int           w;
    int           n;
    logic         got;
    vmask = bus.req_valid | mask;
    if (vmask == '0) vmask[0] = 1'b1;
    w = model_winner(vmask);
    exp_grant_q.push_back(w);
    exp_req_q.push_back('{w: w, a: addr_a[w], d: data_a[w], wr: wr_a[w]});
    drive_payload();
    bus.req_valid = vmask;
    bus.m_ready   = 1'b0;
    spur_drive();
    got = 1'b0;
    n   = 0;
    while (!got && n < 4) begin
      @(negedge clk);
      n++;
      got = (bus.req_ready != '0);
    end
    if (!got) begin
      fail("accept_timeout");
      exp_grant_q.delete();
      exp_req_q.delete();
      bus.req_valid = '0;
      bus.s_valid   = 1'b0;
      spur          = 1'b0;
      return;
    end
    @(posedge clk); #1;
    chk("m_valid_latency", 64'(bus.m_valid), 64'(1));
    chk("grant_after_accept", 64'(grant), 64'(w));
    chk("busy_after_accept", 64'(busy), 64'(1));
    bus.req_valid = vmask & ~onehot(w);
    repeat (mstall) begin
      spur_drive();
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    spur_drive();
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
    spur        = 1'b0;
    repeat (sdelay) begin
      bus.rsp_ready = N'($urandom());
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = sd;
    exp_rsp_q.push_back('{w: w, d: sd});
    repeat (rstall) begin
      rr            = N'($urandom());
      bus.rsp_ready = rr & ~onehot(w);
      @(posedge clk); #1;
    end
    rr            = N'($urandom());
    bus.rsp_ready = rr | onehot(w);
    @(posedge clk); #1;
    bus.s_valid   = 1'b0;
    bus.rsp_ready = '0;
    m_last        = w;
    chk("busy_after_rsp", 64'(busy), 64'(0));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.req_ready != '0) begin
        if (exp_grant_q.size() == 0) fail("req_ready_unexpected");
        else begin
          mw = exp_grant_q.pop_front();
          chk("req_ready_onehot", 64'(bus.req_ready), 64'(onehot(mw)));
        end
      end
      if (busy && bus.req_valid != '0)
        chk("req_ready_while_busy", 64'(bus.req_ready), 64'(0));
      if (prev_stall && bus.m_valid) begin
        chk("stall_m_address", 64'(bus.m_address), 64'(prev_a));
        chk("stall_m_data", 64'(bus.m_data), 64'(prev_d));
        chk("stall_m_write", 64'(bus.m_write), 64'(prev_wr));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_req_q.size() == 0) fail("m_request_unexpected");
        else begin
          mr = exp_req_q.pop_front();
          chk("m_address", 64'(bus.m_address), 64'(mr.a));
          chk("m_data", 64'(bus.m_data), 64'(mr.d));
          chk("m_write", 64'(bus.m_write), 64'(mr.wr));
          chk("grant_owner", 64'(grant), 64'(mr.w));
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_a     = bus.m_address;
      prev_d     = bus.m_data;
      prev_wr    = bus.m_write;
      if (spur && bus.s_valid) begin
        chk("spurious_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("spurious_s_ready", 64'(bus.s_ready), 64'(0));
      end
      if (exp_rsp_q.size() != 0 && bus.s_valid) begin
        ms = exp_rsp_q[0];
        chk("s_ready_follows_owner", 64'(bus.s_ready), 64'(bus.rsp_ready[ms.w]));
        chk("rsp_valid_routing", 64'(bus.rsp_valid), 64'(onehot(ms.w)));
        if (bus.s_ready) begin
          chk("rsp_data", 64'(bus.rsp_data), 64'(ms.d));
          void'(exp_rsp_q.pop_front());
        end
      end else if (bus.rsp_valid != '0) begin
        fail("rsp_valid_unexpected");
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.req_valid   = '0;
    bus.req_address = '0;
    bus.req_data    = '0;
    bus.req_write   = '0;
    bus.rsp_ready   = '0;
    bus.m_ready     = 1'b0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0;
      data_a[i] = '0;
      wr_a[i]   = 1'b0;
    end
    #1;
    chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_m_address", 64'(bus.m_address), 64'(0));
    chk("rst_m_data", 64'(bus.m_data), 64'(0));
    chk("rst_m_write", 64'(bus.m_write), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_s_ready", 64'(bus.s_ready), 64'(0));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    addr_a[0] = 32'h0000_0100;
    data_a[0] = $urandom();
    wr_a[0]   = 1'b0;
    do_txn(3'b001, 0, 0, 0, 32'hDEAD_BEEF);

    repeat (4) begin
      rand_payload(3'b011);
      do_txn(3'b011, 0, 0, 0, $urandom());
    end
    bus.req_valid = '0;

    addr_a[1] = 32'hFFFF_FFFC;
    data_a[1] = 32'hAAAA_AAAA;
    wr_a[1]   = 1'b1;
    addr_a[0] = $urandom();
    data_a[0] = $urandom();
    wr_a[0]   = 1'b0;
    do_txn(3'b011, 5, 1, 0, $urandom());

    rand_payload(3'b100);
    do_txn(3'b100, 0, 0, 3, $urandom());
    do_txn(3'b001, 0, 0, 0, $urandom());

    // Abandon a request mid-flight; last must return to N-1 afterwards.
    bus.req_valid = '0;
    rand_payload(3'b010);
    exp_grant_q.push_back(model_winner(3'b010));
    drive_payload();
    bus.req_valid = 3'b010;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.m_ready   = 1'b0;
    @(negedge clk);
    chk("precond_m_valid", 64'(bus.m_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_grant", 64'(grant), 64'(0));
    exp_grant_q.delete();
    exp_req_q.delete();
    exp_rsp_q.delete();
    m_last = N - 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_payload('1);
    do_txn('1, 1, 0, 1, $urandom());

    repeat (40) begin
      logic [N-1:0] m;
      m = N'($urandom());
      rand_payload(m);
      do_txn(m, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), $urandom());
    end
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", 64'(exp_req_q.size() + exp_grant_q.size() + exp_rsp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
